// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared constants and types for the writeback register file slice
// Provides the register file geometry, the pending-write counter type and the
// wb_params_t record carried from the MEM/WB register into the register file.
package regfile_wb_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int XLEN = 32;
  localparam int PEND_W = 2;
  typedef logic [PEND_W-1:0] pend_cnt_t;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0] rd_data;
  } wb_params_t;
endpackage

// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard: per-register pending-write counters, busy flags and issue gating
// Ports: clk/rst; wb_addr_i retiring destination (0 = none); rs1/rs2_addr_i read
// addresses; issue_valid_i/issue_rd_addr_i issuing destination; rs1/rs2_busy_o
// pending-write flags; issue_ready_o counter for issue_rd_addr_i has room.
module regfile_wb_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = $clog2(NUM_REGS),
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              issue_ready_o
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] dec, inc, underflow;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r] = r != 0 && wb_addr_i == ADDR_W'(r);
      inc[r] = r != 0 && issue_valid_i && issue_rd_addr_i == ADDR_W'(r);
    end
  end
  // A full counter can still accept an issue when WB retires the same register now.
  assign issue_ready_o = !(cnt_q[issue_rd_addr_i] == CNT_MAX && !dec[issue_rd_addr_i]);
  // A write retiring this cycle no longer blocks the reader; its data is bypassed.
  assign rs1_busy_o = cnt_q[rs1_addr_i] != '0 && !(cnt_q[rs1_addr_i] == PEND_W'(1) && dec[rs1_addr_i]);
  assign rs2_busy_o = cnt_q[rs2_addr_i] != '0 && !(cnt_q[rs2_addr_i] == PEND_W'(1) && dec[rs2_addr_i]);
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (inc[r] && issue_ready_o && !dec[r]) ? cnt_q[r] + 1'b1 :
                 (dec[r] && !(inc[r] && issue_ready_o) && cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
      underflow[r] = dec[r] && cnt_q[r] == '0;
    end
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= rst ? '0 : cnt_d[r];
    if (!rst) assert (underflow == '0);
  end
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: architectural register file fed by writeback, with WB->ID bypass and RAW scoreboard
// Ports: clk/rst; wb_params_in writeback (rd_addr 0 = no write); rs1/rs2_addr read
// addresses; rs1/rs2_data combinational read data; rs1/rs2_busy pending-write flags;
// issue_valid/issue_rd_addr issuing destination; issue_ready issue can be accepted.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int NUM_REGS = regfile_wb_pkg::NUM_REGS,
  parameter int ADDR_W = $clog2(NUM_REGS),
  parameter int XLEN = regfile_wb_pkg::XLEN,
  parameter int PEND_W = regfile_wb_pkg::PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  wb_params_t        wb_params_in,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd_addr,
  output logic              issue_ready
);
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  always_comb begin
    regs_d = regs_q;
    if (wb_params_in.rd_addr != '0) regs_d[wb_params_in.rd_addr] = wb_params_in.rd_data;
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= rst ? '0 : regs_d[r];
  end
  assign rs1_data = rs1_addr == '0 ? '0 : wb_params_in.rd_addr == rs1_addr ? wb_params_in.rd_data : regs_q[rs1_addr];
  assign rs2_data = rs2_addr == '0 ? '0 : wb_params_in.rd_addr == rs2_addr ? wb_params_in.rd_data : regs_q[rs2_addr];
  regfile_wb_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W(ADDR_W),
    .PEND_W(PEND_W)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .wb_addr_i(wb_params_in.rd_addr),
    .rs1_addr_i(rs1_addr),
    .rs2_addr_i(rs2_addr),
    .issue_valid_i(issue_valid),
    .issue_rd_addr_i(issue_rd_addr),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy),
    .issue_ready_o(issue_ready)
  );
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and randomized checks of regfile_wb against an in-bench model
module tb_regfile_wb;
  import regfile_wb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wb_params_t wb_in;
  logic [3:0] rs1_addr, rs2_addr, issue_rd_addr;
  logic issue_valid;
  logic [31:0] rs1_data, rs2_data;
  logic rs1_busy, rs2_busy, issue_ready;
  int total = 0;
  int bad = 0;
  logic [31:0] mregs [16];
  int mcnt [16];
  regfile_wb dut (
    .clk(clk),
    .rst(rst),
    .wb_params_in(wb_in),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .issue_valid(issue_valid),
    .issue_rd_addr(issue_rd_addr),
    .issue_ready(issue_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] exp_data(logic [3:0] a);
    return a == 0 ? 32'h0 : (wb_in.rd_addr == a ? wb_in.rd_data : mregs[a]);
  endfunction
  function automatic logic exp_busy(logic [3:0] a);
    return a != 0 && (mcnt[a] - (wb_in.rd_addr == a ? 1 : 0)) > 0;
  endfunction
  function automatic logic exp_ready();
    return issue_rd_addr == 0 || mcnt[issue_rd_addr] < 3 || wb_in.rd_addr == issue_rd_addr;
  endfunction
  task automatic step();
    logic fire;
    fire = issue_valid && exp_ready() && issue_rd_addr != 0;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mregs[i] = 32'h0;
        mcnt[i] = 0;
      end
    end else begin
      if (wb_in.rd_addr != 0) begin
        mregs[wb_in.rd_addr] = wb_in.rd_data;
        if (mcnt[wb_in.rd_addr] > 0) mcnt[wb_in.rd_addr]--;
      end
      if (fire) mcnt[issue_rd_addr]++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wb_in = '{rd_addr: 4'd0, rd_data: 32'h0};
    issue_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    wb_in = '{rd_addr: 4'd3, rd_data: 32'hAA};
    issue_valid = 1'b1;
    issue_rd_addr = 4'd3;
    step();
    step();
    rst = 1'b0;
    idle();
    rs1_addr = 4'd5;
    rs2_addr = 4'd0;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1_data got=%h want=0", rs1_data); end
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL reset_rs2_data got=%h want=0", rs2_data); end
    total++; if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b%b want=00", rs1_busy, rs2_busy); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", issue_ready); end
    rs1_addr = 4'd3;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL reset_drops_write got=%h want=0", rs1_data); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_drops_issue got=%b want=0", rs1_busy); end
  endtask
  task automatic test_bypass();
    issue_valid = 1'b1;
    issue_rd_addr = 4'd4;
    step();
    issue_valid = 1'b0;
    wb_in = '{rd_addr: 4'd4, rd_data: 32'hDEADBEEF};
    rs1_addr = 4'd4;
    #1;
    total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_data got=%h want=deadbeef", rs1_data); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL bypass_busy got=%b want=0", rs1_busy); end
    step();
    idle();
    #1;
    total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_data got=%h want=deadbeef", rs1_data); end
  endtask
  task automatic test_zero_write();
    wb_in = '{rd_addr: 4'd0, rd_data: 32'h1234};
    rs1_addr = 4'd0;
    rs2_addr = 4'd4;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%h want=0", rs1_data); end
    step();
    idle();
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL r0_read got=%h want=0", rs1_data); end
    total++; if (rs2_data !== 32'hDEADBEEF) begin bad++; $display("FAIL r0_write_leak got=%h want=deadbeef", rs2_data); end
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL r0_write_cnt got=%b want=0", rs2_busy); end
  endtask
  task automatic test_pending_r7();
    issue_valid = 1'b1;
    issue_rd_addr = 4'd7;
    step();
    issue_valid = 1'b0;
    rs2_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL r7_busy_%0d got=%b want=1", i, rs2_busy); end
      step();
    end
    wb_in = '{rd_addr: 4'd7, rd_data: 32'h55};
    #1;
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL r7_retire_busy got=%b want=0", rs2_busy); end
    total++; if (rs2_data !== 32'h55) begin bad++; $display("FAIL r7_retire_data got=%h want=55", rs2_data); end
    step();
    idle();
    #1;
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL r7_cleared got=%b want=0", rs2_busy); end
  endtask
  task automatic test_saturate_r9();
    issue_valid = 1'b1;
    issue_rd_addr = 4'd9;
    rs1_addr = 4'd9;
    repeat (3) step();
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL r9_full_ready got=%b want=0", issue_ready); end
    step();
    issue_valid = 1'b0;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL r9_4th_ignored got=%b want=0", issue_ready); end
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL r9_busy got=%b want=1", rs1_busy); end
    wb_in = '{rd_addr: 4'd9, rd_data: 32'h9};
    issue_valid = 1'b1;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL r9_ready_on_retire got=%b want=1", issue_ready); end
    step();
    idle();
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL r9_cnt_held got=%b want=0", issue_ready); end
    for (int i = 0; i < 3; i++) begin
      wb_in = '{rd_addr: 4'd9, rd_data: 32'(i + 16)};
      step();
    end
    idle();
    #1;
    total++; if ({rs1_busy, issue_ready} !== 2'b01) begin bad++; $display("FAIL r9_drained got=%b%b want=01", rs1_busy, issue_ready); end
    total++; if (rs1_data !== 32'd18) begin bad++; $display("FAIL r9_last_data got=%h want=12", rs1_data); end
  endtask
  task automatic test_same_cycle_r2();
    issue_valid = 1'b1;
    issue_rd_addr = 4'd2;
    rs1_addr = 4'd2;
    step();
    wb_in = '{rd_addr: 4'd2, rd_data: 32'h22};
    #1;
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL r2_same_cycle_busy got=%b want=0", rs1_busy); end
    step();
    idle();
    #1;
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL r2_cnt_held got=%b want=1", rs1_busy); end
    total++; if (rs1_data !== 32'h22) begin bad++; $display("FAIL r2_data got=%h want=22", rs1_data); end
    wb_in = '{rd_addr: 4'd2, rd_data: 32'h23};
    step();
    idle();
  endtask
  task automatic test_random();
    logic [3:0] r;
    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd_addr = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(1, 15));
      wb_in.rd_addr = (mcnt[r] > 0 && $urandom_range(0, 3) != 0) ? r : 4'd0;
      wb_in.rd_data = $urandom;
      rs1_addr = $urandom_range(0, 3) == 0 ? wb_in.rd_addr : 4'($urandom_range(0, 15));
      rs2_addr = $urandom_range(0, 3) == 0 ? issue_rd_addr : 4'($urandom_range(0, 15));
      #1;
      total++; if (rs1_data !== exp_data(rs1_addr)) begin bad++; $display("FAIL rnd_rs1_data n=%0d got=%h want=%h", n, rs1_data, exp_data(rs1_addr)); end
      total++; if (rs2_data !== exp_data(rs2_addr)) begin bad++; $display("FAIL rnd_rs2_data n=%0d got=%h want=%h", n, rs2_data, exp_data(rs2_addr)); end
      total++; if (rs1_busy !== exp_busy(rs1_addr)) begin bad++; $display("FAIL rnd_rs1_busy n=%0d got=%b want=%b", n, rs1_busy, exp_busy(rs1_addr)); end
      total++; if (rs2_busy !== exp_busy(rs2_addr)) begin bad++; $display("FAIL rnd_rs2_busy n=%0d got=%b want=%b", n, rs2_busy, exp_busy(rs2_addr)); end
      total++; if (issue_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, issue_ready, exp_ready()); end
      step();
    end
    idle();
  endtask
  initial begin
    idle();
    rs1_addr = 4'd0;
    rs2_addr = 4'd0;
    issue_rd_addr = 4'd0;
    test_reset();
    test_bypass();
    test_zero_write();
    test_pending_r7();
    test_saturate_r9();
    test_same_cycle_r2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
